// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract with optional unsigned saturation and signed overflow.
// The carry chain is cut into STAGES segments; a valid/ready handshake stalls the whole pipe.
module pipelined_adder_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic [1:0]       i_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out,
  output logic             o_overflow,
  output logic             o_saturated
);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder_nbit: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  localparam int SEG = WIDTH / STAGES;

  // {saturated, sum}: clamp only in the SAT modes, keyed on the raw carry/borrow.
  function automatic logic [WIDTH:0] f_saturate(input logic [1:0] mode,
                                                input logic [WIDTH-1:0] r,
                                                input logic cy);
    if (mode == 2'b10 && cy)       return {1'b1, {WIDTH{1'b1}}};
    else if (mode == 2'b11 && !cy) return {1'b1, {WIDTH{1'b0}}};
    else                           return {1'b0, r};
  endfunction

  // b is the effective (possibly inverted) operand, so one rule covers ADD and SUB.
  function automatic logic f_overflow(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] r);
    return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic [WIDTH-1:0] r_a_p    [0:STAGES];
  logic [WIDTH-1:0] r_b_p    [0:STAGES];
  logic [WIDTH-1:0] r_r_p    [0:STAGES];
  logic             r_cy_p   [0:STAGES];
  logic [1:0]       r_mode_p [0:STAGES];
  logic             r_vld_p  [0:STAGES];

  logic             r_vld_out;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_sat;
  logic             w_stall;
  logic [WIDTH:0]   w_sat_sum;

  assign w_stall    = r_vld_out && !i_out_ready;
  assign o_in_ready = !w_stall;

  // Stage 0: input register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)       r_vld_p[0] <= 1'b0;
    else if (!w_stall) r_vld_p[0] <= i_in_valid;
  end

  always_ff @(posedge i_clock) begin
    if (!w_stall && i_in_valid) begin
      r_a_p[0]    <= i_a;
      r_b_p[0]    <= i_b;
      r_cy_p[0]   <= i_c_in;
      r_mode_p[0] <= i_mode;
    end
    r_r_p[0] <= '0;
  end

  // Stages 1..STAGES: one carry-chain segment each
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_b;
    logic             w_ci;
    logic [SEG:0]     w_seg;
    logic [WIDTH-1:0] w_r;

    always_comb begin
      w_b  = r_b_p[k-1];
      w_ci = r_cy_p[k-1];
      if (k == 1 && r_mode_p[k-1][0]) begin
        w_b  = ~r_b_p[k-1];
        w_ci = ~r_cy_p[k-1];
      end
      w_seg = {1'b0, r_a_p[k-1][k*SEG-1 -: SEG]} + {1'b0, w_b[k*SEG-1 -: SEG]}
            + {{SEG{1'b0}}, w_ci};
      w_r = r_r_p[k-1];
      w_r[k*SEG-1 -: SEG] = w_seg[SEG-1:0];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)       r_vld_p[k] <= 1'b0;
      else if (!w_stall) r_vld_p[k] <= r_vld_p[k-1];
    end

    always_ff @(posedge i_clock) begin
      if (!w_stall) begin
        r_a_p[k]    <= r_a_p[k-1];
        r_b_p[k]    <= w_b;
        r_r_p[k]    <= w_r;
        r_cy_p[k]   <= w_seg[SEG];
        r_mode_p[k] <= r_mode_p[k-1];
      end
    end
  end

  assign w_sat_sum = f_saturate(r_mode_p[STAGES], r_r_p[STAGES], r_cy_p[STAGES]);

  // Output stage: saturation and flags; holds through stalls and bubbles
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_vld_out <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_sat     <= 1'b0;
    end else if (!w_stall) begin
      r_vld_out <= r_vld_p[STAGES];
      if (r_vld_p[STAGES]) begin
        r_sat  <= w_sat_sum[WIDTH];
        r_sum  <= w_sat_sum[WIDTH-1:0];
        r_cout <= r_cy_p[STAGES];
        r_ovf  <= f_overflow(r_a_p[STAGES], r_b_p[STAGES], r_r_p[STAGES]);
      end
    end
  end

  assign o_out_valid = r_vld_out;
  assign o_sum       = r_sum;
  assign o_c_out     = r_cout;
  assign o_overflow  = r_ovf;
  assign o_saturated = r_sat;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench for pipelined_adder_nbit (WIDTH=16, STAGES=4, latency 5).
module tb_pipelined_adder_nbit;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_a, i_b;
  logic        i_c_in;
  logic [1:0]  i_mode;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_sum;
  logic        o_c_out, o_overflow, o_saturated;

  int n_checks = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADDS = 2'b10, SUBS = 2'b11;

  pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a(i_a), .i_b(i_b), .i_c_in(i_c_in), .i_mode(i_mode),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_sum(o_sum),
    .o_c_out(o_c_out), .o_overflow(o_overflow), .o_saturated(o_saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at posedge+1; returns at accepting posedge+1.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [1:0] mode, input logic [15:0] es, input logic ec,
                       input logic eo, input logic esat);
    int guard = 0;
    i_in_valid = 1'b1; i_a = a; i_b = b; i_c_in = cin; i_mode = mode;
    @(negedge clk);
    while (!o_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!o_in_ready) chk("issue_timeout", 32'(o_in_ready), 32'd1);
    exp_q.push_back({es, ec, eo, esat});
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: each negedge with valid && ready is one output transfer at the next posedge.
  always @(negedge clk) begin
    if (o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {15'd0, o_sum, o_c_out}, 32'hFFFF_FFFF);
      end else begin
        chk("result{sum,cout,ovf,sat}", {13'd0, o_sum, o_c_out, o_overflow, o_saturated},
            {13'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_in_valid = 1'b0; i_a = '0; i_b = '0; i_c_in = 1'b0;
    i_mode = ADD; i_out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_flags", {29'd0, o_c_out, o_overflow, o_saturated}, 32'd0);
    #19 i_reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);

    // 1: latency of exactly 5 edges
    issue(16'h0001, 16'h0001, 1'b0, ADD, 16'h0002, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("latency_early", 32'(o_out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_on_time", 32'(o_out_valid), 32'd1);
    drain();

    // 2-4 plus extra directed vectors
    issue(16'hFFFF, 16'h0001, 1'b0, ADD,  16'h0000, 1'b1, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, ADDS, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    issue(16'h0005, 16'h0007, 1'b0, SUB,  16'hFFFE, 1'b0, 1'b0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b0, SUBS, 16'h0000, 1'b0, 1'b0, 1'b1);
    issue(16'h0008, 16'h0003, 1'b1, SUB,  16'h0004, 1'b1, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, ADD,  16'h8000, 1'b0, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b0, SUB,  16'h7FFF, 1'b1, 1'b1, 1'b0);
    issue(16'h00FF, 16'h0F00, 1'b1, ADD,  16'h1000, 1'b0, 1'b0, 1'b0);
    issue(16'h1234, 16'h0234, 1'b0, SUBS, 16'h1000, 1'b1, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, ADDS, 16'h8000, 1'b0, 1'b1, 1'b0);
    drain();

    // 5a: back-to-back stream with a 3-cycle output stall
    fork
      begin
        for (int i = 1; i <= 8; i++)
          issue(16'(i), 16'(i), 1'b0, ADD, 16'(2 * i), 1'b0, 1'b0, 1'b0);
      end
      begin
        int g = 0;
        while (!o_out_valid && g < 50) begin
          @(posedge clk); #1;
          g++;
        end
        chk("stream_first_valid", 32'(o_out_valid), 32'd1);
        i_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(o_in_ready), 32'd0);
          chk("stall_hold", {15'd0, o_out_valid, o_sum}, {15'd0, 1'b1, 16'h0002});
        end
        @(posedge clk); #1;
        i_out_ready = 1'b1;
      end
    join
    drain();

    // 5b: continuous ready -> one result per cycle
    fork
      begin
        for (int i = 1; i <= 8; i++)
          issue(16'h1000 + 16'(i), 16'(i), 1'b0, ADD, 16'h1000 + 16'(2 * i), 1'b0, 1'b0, 1'b0);
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!o_out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        for (int j = 0; j < 8; j++) begin
          chk("throughput_valid", 32'(o_out_valid), 32'd1);
          @(negedge clk);
        end
      end
    join
    drain();

    // 6: asynchronous reset with operations in flight
    issue(16'h0010, 16'h0010, 1'b0, ADD, 16'h0020, 1'b0, 1'b0, 1'b0);
    issue(16'h0011, 16'h0011, 1'b0, ADD, 16'h0022, 1'b0, 1'b0, 1'b0);
    issue(16'h0012, 16'h0012, 1'b0, ADD, 16'h0024, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_valid", 32'(o_out_valid), 32'd1);
    i_reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_valid", 32'(o_out_valid), 32'd0);
    chk("async_rst_sum", 32'(o_sum), 32'd0);
    repeat (2) @(posedge clk);
    #3 i_reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_stale_output", 32'(o_out_valid), 32'd0);
    end
    @(posedge clk); #1;
    issue(16'h0003, 16'h0004, 1'b0, ADD, 16'h0007, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("post_rst_latency_early", 32'(o_out_valid), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_latency", 32'(o_out_valid), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nbit.md
Name: pipelined_adder_nbit

Overview:
Parametrised, pipelined successor to the team's registered 8-bit full adder. It supports add/subtract with optional unsigned saturation and signed-overflow reporting. The carry chain is split into STAGES registered segments so that wide operands close timing. Valid/ready handshakes on input and output let it sit between streaming datapath blocks.

Parameters:
WIDTH, 16, operand and result width in bits; must be >= 2.
STAGES, 4, number of carry-chain segments; must be >= 1. WIDTH % STAGES != 0 is an elaboration error.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
In_Valid  input  1  operand set on A/B/C_in/Mode is valid.
In_Ready  output  1  block accepts an operand set this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
C_in  input  1  carry-in for ADD modes; borrow-in for SUB modes.
Mode  input  2  00 ADD, 01 SUB, 10 ADD_SAT, 11 SUB_SAT.
Out_Valid  output  1  result outputs are valid.
Out_Ready  input  1  downstream accepts the result.
SUM  output  WIDTH  result.
C_out  output  1  carry-out; 1 = no borrow in SUB modes.
Overflow  output  1  signed overflow of the unclamped result.
Saturated  output  1  result was clamped (SAT modes only).

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits are 0. Out_Valid, SUM, C_out, Overflow and Saturated are 0. In_Ready is 1 after release. All in-flight operations are discarded, and none emerge after release.
- Transfer:
  - Input transfer occurs when In_Valid && In_Ready at a rising edge. A, B, C_in and Mode are captured together in the input register (stage 0).
  - Output transfer occurs when Out_Valid && Out_Ready.
- Latency: STAGES+1 cycles from the accepting edge to Out_Valid=1, assuming no stall. With STAGES=1 this is 2 cycles.
- Throughput: one operation per cycle when not stalled.
- Stall:
  - stall = Out_Valid && !Out_Ready.
  - In_Ready = !stall, combinational.
  - While stalled, every pipeline register (data and valid) holds.
  - SUM, C_out, Overflow and Saturated stay stable until the output transfer.
- Bubbles: not collapsed. A bubble advances like data when not stalled.
- Arithmetic:
  - ADD/ADD_SAT: {C_out, R} = A + B + C_in.
  - SUB/SUB_SAT: {C_out, R} = A + ~B + !C_in, i.e. A - B - C_in. C_out=0 means a borrow occurred.
  - The result is full modulo 2^WIDTH. Operands are unsigned for saturation and two's-complement for Overflow.
- Segmentation: SEG = WIDTH/STAGES.
  - Pipeline stage k (1..STAGES) adds bits [k*SEG-1:(k-1)*SEG] using the carry registered from stage k-1. Stage 1 uses the effective carry-in.
  - Upper operand bits are skew-delayed.
  - Completed lower result bits are delay-aligned so that all bits of one operation exit together.
  - The Mode, MSB and valid bits travel with the operation.
- Overflow:
  - ADD modes: A[MSB]==B[MSB] && R[MSB]!=A[MSB].
  - SUB modes: A[MSB]!=B[MSB] && R[MSB]!=A[MSB].
  - Reported in all modes and computed on the unclamped R.
- Saturation:
  - ADD_SAT with C_out=1: SUM = all ones, Saturated=1.
  - SUB_SAT with C_out=0: SUM = 0, Saturated=1.
  - Otherwise SUM = R and Saturated=0.
  - ADD and SUB never set Saturated.
  - C_out always reports the raw carry.
- When Out_Valid=0, the result outputs hold their last values.
- Simultaneous output transfer and input accept in the same cycle is legal; the pipeline advances normally.
- Out_Ready is ignored while Out_Valid=0.

Test Plan:
(WIDTH=16, STAGES=4, latency 5.)
1. ADD A=0x0001 B=0x0001 C_in=0 -> exactly 5 edges after acceptance: SUM=0x0002 C_out=0 Overflow=0 Saturated=0 Out_Valid=1.
2. Carry across all segments, ADD A=0xFFFF B=0x0001 C_in=0 -> SUM=0x0000 C_out=1 Overflow=0. The same operands with ADD_SAT -> SUM=0xFFFF Saturated=1 C_out=1.
3. SUB A=0x0005 B=0x0007 C_in=0 -> SUM=0xFFFE C_out=0. SUB_SAT -> SUM=0x0000 Saturated=1. SUB A=0x0008 B=0x0003 C_in=1 -> SUM=0x0004 C_out=1.
4. Signed overflow: ADD A=0x7FFF B=0x0001 -> SUM=0x8000 Overflow=1. SUB A=0x8000 B=0x0001 C_in=0 -> SUM=0x7FFF Overflow=1.
5. Back-to-back stream, Mode=ADD:
   - Stimulus: 8 operations A=i, B=i (i=1..8), C_in=0, issued on consecutive cycles; Out_Ready held 0 for 3 cycles after the first result.
   - Required: In_Ready=0 throughout the stall and result 0x0002 held stable. All results 0x0002..0x0010 emerge in order, none lost or duplicated. With Out_Ready=1 continuously, one result per cycle.
6. Reset mid-operation: assert Reset with 3 operations in flight, asynchronously between edges -> Out_Valid and SUM go to 0 immediately. After release, no stale results appear and a new ADD 0x0003+0x0004 yields 0x0007 after 5 cycles.
